// File: rtl/rd_cache_pkg.sv
// Shared types and helpers for the direct-mapped read cache.
package rd_cache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        FETCH
    } state_e;

    localparam int unsigned OFFSET_W = 2;

    function automatic int unsigned log2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rd_cache_array.sv
// Valid/tag/data storage for the read cache: async read, one fill port,
// tag-checked invalidate and whole-array flush.
module rd_cache_array
    import rd_cache_pkg::*;
#(
    parameter int unsigned LINES = 8,
    parameter int unsigned IDX_W = 3,
    parameter int unsigned TAG_W = 19
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    output logic [31:0]      rd_data,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic [31:0]      wr_data,
    input  logic             inv_en,
    input  logic [IDX_W-1:0] inv_idx,
    input  logic [TAG_W-1:0] inv_tag,
    input  logic             flush
);

    logic [LINES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [TAG_W-1:0] tag_d  [LINES];
    logic [31:0]      data_q [LINES];
    logic [31:0]      data_d [LINES];

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (wr_en) begin
            valid_d[wr_idx] = 1'b1;
            tag_d[wr_idx]   = wr_tag;
            data_d[wr_idx]  = wr_data;
        end
        // Match against the tag the line holds after this cycle, so a same-cycle fill loses
        if (inv_en && (tag_d[inv_idx] == inv_tag)) valid_d[inv_idx] = 1'b0;
        if (flush) valid_d = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) valid_q <= '0;
        else        valid_q <= valid_d;
    end

    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/rd_cache_ctrl.sv
// Direct-mapped one-word-per-line read cache in front of the SPI memory
// reader, with uncached region, flush, snoop invalidate and hit/miss counters.
module rd_cache_ctrl
    import rd_cache_pkg::*;
#(
    parameter int unsigned       ADDR_W        = 24,
    parameter int unsigned       LINES         = 8,
    parameter logic [ADDR_W-1:0] UNCACHED_BASE = 24'hC00000,
    parameter int unsigned       CNT_W         = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [31:0]       resp_data,
    output logic              mem_start,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_data,
    input  logic              mem_done,
    input  logic              flush,
    input  logic              inv_valid,
    input  logic [ADDR_W-1:0] inv_addr,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);

    localparam int unsigned IDX_W  = log2(LINES);
    localparam int unsigned WORD_W = ADDR_W - OFFSET_W;
    localparam int unsigned TAG_W  = WORD_W - IDX_W;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              resp_valid_q, resp_valid_d;
    logic [31:0]       resp_data_q, resp_data_d;
    logic              mem_start_q, mem_start_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;
    logic              drop_q, drop_d;

    logic [IDX_W-1:0]  lk_idx;
    logic [TAG_W-1:0]  lk_tag;
    logic [WORD_W-1:0] inv_word;
    logic              rd_valid;
    logic [TAG_W-1:0]  rd_tag;
    logic [31:0]       rd_data;
    logic              cacheable;
    logic              hit;
    logic              drop_now;
    logic              wr_en;

    assign lk_idx    = addr_q[IDX_W+OFFSET_W-1:OFFSET_W];
    assign lk_tag    = addr_q[ADDR_W-1:IDX_W+OFFSET_W];
    assign inv_word  = WORD_W'(inv_addr >> OFFSET_W);
    assign cacheable = addr_q < UNCACHED_BASE;
    assign hit       = rd_valid && (rd_tag == lk_tag) && cacheable;
    // A flush or matching snoop during the fetch poisons the fill but not the response
    assign drop_now  = drop_q || flush
                    || (inv_valid && (inv_word == addr_q[ADDR_W-1:OFFSET_W]));

    rd_cache_array #(
        .LINES (LINES),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_array (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_idx   (lk_idx),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    (wr_en),
        .wr_idx   (lk_idx),
        .wr_tag   (lk_tag),
        .wr_data  (mem_data),
        .inv_en   (inv_valid),
        .inv_idx  (inv_word[IDX_W-1:0]),
        .inv_tag  (inv_word[WORD_W-1:IDX_W]),
        .flush    (flush)
    );

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        resp_valid_d = 1'b0;
        resp_data_d  = resp_data_q;
        mem_start_d  = mem_start_q;
        mem_addr_d   = mem_addr_q;
        hit_cnt_d    = hit_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        drop_d       = drop_q;
        wr_en        = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit) begin
                    resp_data_d  = rd_data;
                    resp_valid_d = 1'b1;
                    if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 1'b1;
                    state_d = IDLE;
                end else begin
                    mem_addr_d  = {addr_q[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
                    mem_start_d = 1'b1;
                    state_d     = FETCH;
                end
            end
            FETCH: begin
                if (mem_done) begin
                    mem_start_d  = 1'b0;
                    resp_data_d  = mem_data;
                    resp_valid_d = 1'b1;
                    if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 1'b1;
                    wr_en   = cacheable && !drop_now;
                    drop_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    drop_d = drop_now;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            mem_start_q  <= 1'b0;
            mem_addr_q   <= '0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
            drop_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            mem_start_q  <= mem_start_d;
            mem_addr_q   <= mem_addr_d;
            hit_cnt_q    <= hit_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
            drop_q       <= drop_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign mem_start  = mem_start_q;
    assign mem_addr   = mem_addr_q;
    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;

endmodule

// File: tb/tb_rd_cache_ctrl.sv
// Scoreboard bench for rd_cache_ctrl: a word-keyed cache model predicts
// responses and counters; a monitor checks every resp_valid pulse.
module tb_rd_cache_ctrl;

    localparam int unsigned LINES   = 8;
    localparam int unsigned CNT_MAX = 15;
    localparam logic [23:0] UNC     = 24'hC00000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic [23:0] req_addr = '0;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        mem_start;
    logic [23:0] mem_addr;
    logic [31:0] mem_data = '0;
    logic        mem_done = 1'b0;
    logic        flush = 1'b0;
    logic        inv_valid = 1'b0;
    logic [23:0] inv_addr = '0;
    logic [3:0]  hit_count;
    logic [3:0]  miss_count;

    rd_cache_ctrl #(
        .ADDR_W        (24),
        .LINES         (LINES),
        .UNCACHED_BASE (UNC),
        .CNT_W         (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .mem_start  (mem_start),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_done   (mem_done),
        .flush      (flush),
        .inv_valid  (inv_valid),
        .inv_addr   (inv_addr),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        int unsigned hits;
        int unsigned misses;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mdl[int unsigned];   // cached word address -> data
    int unsigned hit_cnt = 0;
    int unsigned miss_cnt = 0;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic mdl_fill(input int unsigned w, input logic [31:0] d);
        int unsigned ev[$];
        foreach (mdl[k]) if ((k % LINES) == (w % LINES)) ev.push_back(k);
        foreach (ev[i]) mdl.delete(ev[i]);
        mdl[w] = d;
    endtask

    task automatic mdl_reset();
        mdl.delete();
        hit_cnt  = 0;
        miss_cnt = 0;
    endtask

    always @(negedge clk) begin
        if (rst_n && resp_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got resp 0x%08h expected none at %0t", resp_data, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("resp_data", resp_data, e.data);
                chk("hit_count", 32'(hit_count), e.hits);
                chk("miss_count", 32'(miss_count), e.misses);
            end
        end
    end

    // Called at a negedge with the DUT idle; returns at the negedge the response is visible.
    // mode: 0 plain, 1 flush (lookup/fetch), 2 inv same word (lookup/fetch),
    //       3 flush with mem_done, 4 inv same word with mem_done, 5 inv same idx other tag in fetch
    task automatic do_read(input logic [23:0] a, input int unsigned mode, input logic [31:0] dval);
        int unsigned w;
        bit          cach;
        logic [23:0] ia;
        int unsigned lat;
        w    = a >> 2;
        cach = a < UNC;
        chk("req_ready_idle", req_ready, 1);
        req_valid = 1'b1;
        req_addr  = a;
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = 24'($urandom);
        chk("req_ready_busy", req_ready, 0);
        if (cach && mdl.exists(w)) begin
            if (hit_cnt < CNT_MAX) hit_cnt++;
            exp_q.push_back('{mdl[w], hit_cnt, miss_cnt});
            if (mode == 1) flush = 1'b1;
            if (mode == 2) begin inv_valid = 1'b1; inv_addr = a; end
            @(negedge clk);
            flush = 1'b0;
            inv_valid = 1'b0;
            chk("hit_latency", resp_valid, 1);
            chk("hit_no_fetch", mem_start, 0);
            if (mode == 1) mdl.delete();
            if (mode == 2) mdl.delete(w);
        end else begin
            @(negedge clk);
            chk("miss_mem_start", mem_start, 1);
            chk("miss_mem_addr", 32'(mem_addr), 32'({a[23:2], 2'b00}));
            ia = a;
            ia[1:0] = 2'($urandom_range(0, 3));
            if (mode == 5) ia[23:2] = a[23:2] ^ 22'(LINES << $urandom_range(0, 2));
            if (mode == 1) flush = 1'b1;
            if (mode == 2 || mode == 5) begin inv_valid = 1'b1; inv_addr = ia; end
            if (mode == 1 || mode == 2 || mode == 5) begin
                @(negedge clk);
                flush = 1'b0;
                inv_valid = 1'b0;
                chk("fetch_hold", mem_start, 1);
            end
            lat = $urandom_range(0, 3);
            repeat (lat) begin
                @(negedge clk);
                chk("fetch_hold", mem_start, 1);
            end
            mem_done = 1'b1;
            mem_data = dval;
            if (mode == 3) flush = 1'b1;
            if (mode == 4) begin inv_valid = 1'b1; inv_addr = ia; end
            if (miss_cnt < CNT_MAX) miss_cnt++;
            exp_q.push_back('{dval, hit_cnt, miss_cnt});
            @(negedge clk);
            mem_done = 1'b0;
            flush = 1'b0;
            inv_valid = 1'b0;
            mem_data = 32'($urandom);
            chk("miss_resp", resp_valid, 1);
            chk("fetch_end", mem_start, 0);
            if (mode == 1 || mode == 3) mdl.delete();
            if (mode == 5) mdl.delete(int'(ia >> 2));
            if (cach && (mode == 0 || mode == 5)) mdl_fill(w, dval);
        end
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        mdl.delete();
    endtask

    task automatic do_inv(input logic [23:0] a);
        inv_valid = 1'b1;
        inv_addr  = a;
        @(negedge clk);
        inv_valid = 1'b0;
        mdl.delete(int'(a >> 2));
    endtask

    function automatic logic [23:0] rand_addr();
        int unsigned r;
        r = $urandom_range(0, 99);
        if (r < 5)  return 24'hBFFFFC;
        if (r < 20) return UNC + 24'($urandom_range(0, 15) * 4);
        return 24'(($urandom_range(0, 31) << 2) | $urandom_range(0, 3));
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_data", resp_data, 0);
        chk("rst_mem_start", mem_start, 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_hit_count", 32'(hit_count), 0);
        chk("rst_miss_count", 32'(miss_count), 0);

        // Cold miss then hit
        do_read(24'h000104, 0, 32'hDEADBEEF);
        do_read(24'h000104, 0, 32'h0);
        chk("first_hit_count", 32'(hit_count), 1);
        chk("first_miss_count", 32'(miss_count), 1);

        // Conflict on idx 1
        do_read(24'h000004, 0, 32'h11111111);
        do_read(24'h000024, 0, 32'h22222222);
        do_read(24'h000004, 0, 32'h33333333);

        // Uncached region
        do_read(24'hC00010, 0, 32'h44444444);
        do_read(24'hC00010, 0, 32'h55555555);
        chk("uncached_miss_count", 32'(miss_count), 6);

        // Flush idle and mid-fetch
        do_read(24'h000200, 0, 32'h66666666);
        do_flush();
        do_read(24'h000200, 0, 32'h77777777);
        do_read(24'h000300, 1, 32'h88888888);
        do_read(24'h000300, 0, 32'h99999999);

        // Snoop invalidate: matching tag kills, other tag on same idx spares
        do_read(24'h000104, 0, 32'hAAAAAAAA);
        do_inv(24'h000104);
        do_read(24'h000104, 0, 32'hBBBBBBBB);
        do_inv(24'h000124);
        do_read(24'h000104, 0, 32'h0);

        // Reset while fetching
        req_valid = 1'b1;
        req_addr  = 24'h000500;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_mem_start", mem_start, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        mdl_reset();
        chk("midrst_mem_start", mem_start, 0);
        chk("midrst_hit_count", 32'(hit_count), 0);
        chk("midrst_miss_count", 32'(miss_count), 0);
        mem_done = 1'b1;
        mem_data = 32'hCAFEF00D;
        @(negedge clk);
        mem_done = 1'b0;
        repeat (3) begin
            chk("midrst_no_resp", resp_valid, 0);
            @(negedge clk);
        end
        chk("midrst_req_ready", req_ready, 1);

        // Hit counter saturation: 2^4+3 hits
        do_read(24'h000040, 0, 32'h12345678);
        for (int i = 0; i < 19; i++) do_read(24'h000040, 0, 32'h0);
        chk("hit_saturate", 32'(hit_count), 15);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            int unsigned r;
            r = $urandom_range(0, 99);
            if (r < 8)       do_flush();
            else if (r < 18) do_inv(rand_addr());
            r = $urandom_range(0, 99);
            do_read(rand_addr(), (r < 50) ? 0 : ((r - 50) / 10) + 1, 32'($urandom));
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
